// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - EX/MEM to MEM/WB bundle for the memory/writeback stage
// Ports (all grouped here, clock and reset stay on the stage itself):
//   EX/MEM side : RegWrite, MemRead, MemWrite, MemToReg, movIn, jumpIn, whb,
//                 ALUResult, ReadData2, WriteReg, PCAddressIn
//   Stage back  : Stall (combinational hold request to upstream)
//   MEM/WB side : RegWriteOut, MemToRegOut, movOut, jumpOut, ReadDataOut,
//                 ALUResultOut, PCAddressOut, WriteRegOut
// master = upstream/consumer view, slave = mem_wb_stage view.
interface mem_wb_stage_if;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        movIn;
    logic        jumpIn;
    logic [1:0]  whb;
    logic [31:0] ALUResult;
    logic [31:0] ReadData2;
    logic [4:0]  WriteReg;
    logic [31:0] PCAddressIn;

    logic        Stall;

    logic        RegWriteOut;
    logic        MemToRegOut;
    logic        movOut;
    logic        jumpOut;
    logic [31:0] ReadDataOut;
    logic [31:0] ALUResultOut;
    logic [31:0] PCAddressOut;
    logic [4:0]  WriteRegOut;

    modport master (
        output RegWrite, MemRead, MemWrite, MemToReg, movIn, jumpIn, whb,
               ALUResult, ReadData2, WriteReg, PCAddressIn,
        input  Stall,
        input  RegWriteOut, MemToRegOut, movOut, jumpOut, ReadDataOut,
               ALUResultOut, PCAddressOut, WriteRegOut
    );

    modport slave (
        input  RegWrite, MemRead, MemWrite, MemToReg, movIn, jumpIn, whb,
               ALUResult, ReadData2, WriteReg, PCAddressIn,
        output Stall,
        output RegWriteOut, MemToRegOut, movOut, jumpOut, ReadDataOut,
               ALUResultOut, PCAddressOut, WriteRegOut
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - data memory access plus MEM/WB pipeline register with load stall
// Ports:
//   Clk   - rising-edge clock for FSM, data memory and MEM/WB register
//   Rst_n - asynchronous active-low reset (memory contents are not reset)
//   bus   - mem_wb_stage_if.slave: EX/MEM inputs, Stall, MEM/WB outputs
// Loads take two cycles: the first cycle stalls upstream and pushes a bubble
// while the synchronous RAM read completes; the second captures the data.
module mem_wb_stage (
    input  logic              Clk,
    input  logic              Rst_n,
    mem_wb_stage_if.slave     bus
);
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] mem [0:1023];
    logic [31:0] rdata_q;

    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        mov_q, mov_d;
    logic        jump_q, jump_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] pc_address_q, pc_address_d;
    logic [4:0]  write_reg_q, write_reg_d;

    logic        is_load;
    logic        wr_en;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [31:0] load_data;
    logic [9:0]  word_addr;

    // A simultaneous read+write request is treated purely as a store.
    assign is_load   = bus.MemRead & ~bus.MemWrite;
    assign word_addr = bus.ALUResult[11:2];
    // Stores only complete in IDLE so a store behind a load waits for it.
    assign wr_en     = Rst_n & (state_q == IDLE) & bus.MemWrite;
    assign bus.Stall = Rst_n & (state_q == IDLE) & is_load;

    always_comb begin
        byte_en = 4'b1111;
        wr_data = bus.ReadData2;
        case (bus.whb)
            2'b01: begin
                byte_en = bus.ALUResult[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.ReadData2[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b0001 << bus.ALUResult[1:0];
                wr_data = {4{bus.ReadData2[7:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = bus.ReadData2;
            end
        endcase
    end

    // Lane extraction uses the address/size still held upstream during LOAD_WAIT.
    always_comb begin
        load_data = rdata_q;
        case (bus.whb)
            2'b01: begin
                if (bus.ALUResult[1])
                    load_data = {{16{rdata_q[31]}}, rdata_q[31:16]};
                else
                    load_data = {{16{rdata_q[15]}}, rdata_q[15:0]};
            end
            2'b10: begin
                case (bus.ALUResult[1:0])
                    2'd0:    load_data = {{24{rdata_q[7]}},  rdata_q[7:0]};
                    2'd1:    load_data = {{24{rdata_q[15]}}, rdata_q[15:8]};
                    2'd2:    load_data = {{24{rdata_q[23]}}, rdata_q[23:16]};
                    default: load_data = {{24{rdata_q[31]}}, rdata_q[31:24]};
                endcase
            end
            default: load_data = rdata_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && byte_en[b])
                mem[word_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
        rdata_q <= mem[word_addr];
    end

    always_comb begin
        state_d      = IDLE;
        reg_write_d  = bus.RegWrite;
        mem_to_reg_d = bus.MemToReg;
        mov_d        = bus.movIn;
        jump_d       = bus.jumpIn;
        read_data_d  = read_data_q;
        alu_result_d = bus.ALUResult;
        pc_address_d = bus.PCAddressIn;
        write_reg_d  = bus.WriteReg;
        if (state_q == IDLE) begin
            if (is_load) begin
                state_d     = LOAD_WAIT;
                reg_write_d = 1'b0;
                mov_d       = 1'b0;
                jump_d      = 1'b0;
            end
        end else begin
            read_data_d = load_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mov_q        <= 1'b0;
            jump_q       <= 1'b0;
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            pc_address_q <= 32'd0;
            write_reg_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mov_q        <= mov_d;
            jump_q       <= jump_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            pc_address_q <= pc_address_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign bus.RegWriteOut  = reg_write_q;
    assign bus.MemToRegOut  = mem_to_reg_q;
    assign bus.movOut       = mov_q;
    assign bus.jumpOut      = jump_q;
    assign bus.ReadDataOut  = read_data_q;
    assign bus.ALUResultOut = alu_result_q;
    assign bus.PCAddressOut = pc_address_q;
    assign bus.WriteRegOut  = write_reg_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
    logic Clk;
    logic Rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] exp_rd;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_in();
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.movIn       = 1'b0;
        bus.jumpIn      = 1'b0;
        bus.whb         = 2'b00;
        bus.ALUResult   = 32'd0;
        bus.ReadData2   = 32'd0;
        bus.WriteReg    = 5'd0;
        bus.PCAddressIn = 32'd0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input logic both);
        clear_in();
        bus.MemWrite  = 1'b1;
        bus.MemRead   = both;
        bus.whb       = size;
        bus.ALUResult = addr;
        bus.ReadData2 = data;
        #1;
        chk("store_stall", {31'd0, bus.Stall}, 32'd0);
        tick();
        chk("store_alu_out", bus.ALUResultOut, addr);
        chk("store_rd_hold", bus.ReadDataOut, exp_rd);
        chk("store_regwrite", {31'd0, bus.RegWriteOut}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] exp, input logic [4:0] wr);
        clear_in();
        bus.MemRead     = 1'b1;
        bus.RegWrite    = 1'b1;
        bus.MemToReg    = 1'b1;
        bus.movIn       = 1'b1;
        bus.whb         = size;
        bus.ALUResult   = addr;
        bus.WriteReg    = wr;
        bus.PCAddressIn = 32'h100 + {27'd0, wr};
        #1;
        chk({tag, "_stall1"}, {31'd0, bus.Stall}, 32'd1);
        tick();
        chk({tag, "_bubble_rw"}, {31'd0, bus.RegWriteOut}, 32'd0);
        chk({tag, "_bubble_mov"}, {31'd0, bus.movOut}, 32'd0);
        chk({tag, "_wait_stall"}, {31'd0, bus.Stall}, 32'd0);
        tick();
        chk({tag, "_data"}, bus.ReadDataOut, exp);
        chk({tag, "_rw"}, {31'd0, bus.RegWriteOut}, 32'd1);
        chk({tag, "_wreg"}, {27'd0, bus.WriteRegOut}, {27'd0, wr});
        chk({tag, "_m2r"}, {31'd0, bus.MemToRegOut}, 32'd1);
        exp_rd = exp;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        exp_rd = 32'd0;
        clear_in();
        Rst_n = 1'b0;
        bus.MemRead = 1'b1;
        #3;
        chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
        chk("rst_rd", bus.ReadDataOut, 32'd0);
        chk("rst_alu", bus.ALUResultOut, 32'd0);
        chk("rst_rw", {31'd0, bus.RegWriteOut}, 32'd0);
        tick();
        clear_in();
        Rst_n = 1'b1;

        do_store(32'h10, 32'hDEADBEEF, 2'b00, 1'b0);
        do_load("ld_w10", 32'h10, 2'b00, 32'hDEADBEEF, 5'd7);

        do_store(32'h12, 32'h0000005A, 2'b10, 1'b0);
        do_load("ld_w10b", 32'h10, 2'b00, 32'hDE5ABEEF, 5'd8);
        do_load("ld_b13", 32'h13, 2'b10, 32'hFFFFFFDE, 5'd9);
        do_load("ld_b12", 32'h12, 2'b10, 32'h0000005A, 5'd10);

        do_store(32'h20, 32'h00008001, 2'b00, 1'b0);
        do_load("ld_h20", 32'h20, 2'b01, 32'hFFFF8001, 5'd11);
        do_load("ld_h22", 32'h22, 2'b01, 32'h00000000, 5'd12);
        do_store(32'h22, 32'h1234ABCD, 2'b01, 1'b0);
        do_load("ld_w20", 32'h20, 2'b00, 32'hABCD8001, 5'd13);

        clear_in();
        bus.RegWrite    = 1'b1;
        bus.ALUResult   = 32'h1234;
        bus.WriteReg    = 5'd5;
        bus.movIn       = 1'b1;
        bus.jumpIn      = 1'b1;
        bus.PCAddressIn = 32'h400;
        #1;
        chk("pt_stall", {31'd0, bus.Stall}, 32'd0);
        tick();
        chk("pt_alu", bus.ALUResultOut, 32'h1234);
        chk("pt_wreg", {27'd0, bus.WriteRegOut}, 32'd5);
        chk("pt_rw", {31'd0, bus.RegWriteOut}, 32'd1);
        chk("pt_mov", {31'd0, bus.movOut}, 32'd1);
        chk("pt_jump", {31'd0, bus.jumpOut}, 32'd1);
        chk("pt_pc", bus.PCAddressOut, 32'h400);
        chk("pt_rd_hold", bus.ReadDataOut, 32'hABCD8001);

        do_store(32'h30, 32'h11223344, 2'b00, 1'b1);
        do_load("ld_w30", 32'h30, 2'b00, 32'h11223344, 5'd14);

        clear_in();
        bus.MemRead   = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.ALUResult = 32'h30;
        bus.WriteReg  = 5'd3;
        #1;
        chk("rl_stall1", {31'd0, bus.Stall}, 32'd1);
        tick();
        #2;
        Rst_n = 1'b0;
        bus.MemWrite  = 1'b1;
        bus.ReadData2 = 32'h0;
        bus.ALUResult = 32'h10;
        #1;
        chk("rl_stall0", {31'd0, bus.Stall}, 32'd0);
        chk("rl_rd0", bus.ReadDataOut, 32'd0);
        chk("rl_alu0", bus.ALUResultOut, 32'd0);
        chk("rl_wreg0", {27'd0, bus.WriteRegOut}, 32'd0);
        tick();
        chk("rl_hold_rd", bus.ReadDataOut, 32'd0);
        clear_in();
        Rst_n = 1'b1;
        exp_rd = 32'd0;
        tick();
        chk("rl_no_data", bus.ReadDataOut, 32'd0);
        chk("rl_idle_stall", {31'd0, bus.Stall}, 32'd0);
        do_store(32'h40, 32'hDEADBEEF, 2'b00, 1'b0);
        do_load("rl_ld40", 32'h40, 2'b00, 32'hDEADBEEF, 5'd15);
        do_load("rl_ld10", 32'h10, 2'b00, 32'hDE5ABEEF, 5'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
